// File: rtl/segre_pkg.sv
// Shared RV32I types for the segre encoder slice: opcodes, instruction formats,
// the canonical NOP and a sign-fit helper used by the optional immediate range check.
package segre_pkg;

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'h03,
      OPC_MISC_MEM = 7'h0F,
      OPC_OP_IMM   = 7'h13,
      OPC_AUIPC    = 7'h17,
      OPC_STORE    = 7'h23,
      OPC_OP       = 7'h33,
      OPC_LUI      = 7'h37,
      OPC_BRANCH   = 7'h63,
      OPC_JALR     = 7'h67,
      OPC_JAL      = 7'h6F,
      OPC_SYSTEM   = 7'h73
   } opcode_e;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } instr_fmt_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // True when v is representable as a signed value of the given bit count.
   function automatic logic sfits(input logic [31:0] v, input int unsigned bits);
      logic [31:0] hi;
      hi = 32'($signed(v) >>> (bits - 1));
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/segre_instr_pack.sv
// Combinational RV32I field-to-word packer with an error flag.
// Define SEGRE_ENC_RANGE_CHECK_EN to reject immediates that do not fit their format.
module segre_instr_pack
   import segre_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned REG_SIZE  = 5
) (
   input  logic [2:0]           fmt_i,
   input  logic [6:0]           opcode_i,
   input  logic [2:0]           funct3_i,
   input  logic [6:0]           funct7_i,
   input  logic [REG_SIZE-1:0]  rd_i,
   input  logic [REG_SIZE-1:0]  rs1_i,
   input  logic [REG_SIZE-1:0]  rs2_i,
   input  logic [WORD_SIZE-1:0] imm_i,
   output logic [WORD_SIZE-1:0] word_o,
   output logic                 err_o
);

   logic range_ok;

   always_comb begin
      word_o   = NOP_INSTR;
      err_o    = 1'b0;
      range_ok = 1'b1;
      case (instr_fmt_e'(fmt_i))
         FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         FMT_I: begin
            word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
`ifdef SEGRE_ENC_RANGE_CHECK_EN
            range_ok = sfits(imm_i, 12);
`endif
         end
         FMT_S: begin
            word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
`ifdef SEGRE_ENC_RANGE_CHECK_EN
            range_ok = sfits(imm_i, 12);
`endif
         end
         FMT_B: begin
            word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], opcode_i};
`ifdef SEGRE_ENC_RANGE_CHECK_EN
            range_ok = sfits(imm_i, 13) && !imm_i[0];
`endif
         end
         FMT_U: begin
            word_o = {imm_i[31:12], rd_i, opcode_i};
`ifdef SEGRE_ENC_RANGE_CHECK_EN
            range_ok = (imm_i[11:0] == '0);
`endif
         end
         FMT_J: begin
            word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
`ifdef SEGRE_ENC_RANGE_CHECK_EN
            range_ok = sfits(imm_i, 21) && !imm_i[0];
`endif
         end
         default: err_o = 1'b1;
      endcase
      if (!range_ok) begin
         word_o = NOP_INSTR;
         err_o  = 1'b1;
      end
   end

endmodule

// File: rtl/segre_instr_encoder.sv
// Streaming RV32I assembler: packs decoded field sets and writes them to imem at
// consecutive word addresses. SEGRE_ENC_RANGE_CHECK_EN enables immediate range checks.
module segre_instr_encoder
   import segre_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned REG_SIZE  = 5,
   parameter int unsigned ADDR_SIZE = 32,
   parameter int unsigned CNT_SIZE  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [ADDR_SIZE-1:0] base_addr_i,
   input  logic [CNT_SIZE-1:0]  count_i,
   input  logic                 fld_valid_i,
   output logic                 fld_ready_o,
   input  logic [2:0]           fld_fmt_i,
   input  logic [6:0]           fld_opcode_i,
   input  logic [2:0]           fld_funct3_i,
   input  logic [6:0]           fld_funct7_i,
   input  logic [REG_SIZE-1:0]  fld_rd_i,
   input  logic [REG_SIZE-1:0]  fld_rs1_i,
   input  logic [REG_SIZE-1:0]  fld_rs2_i,
   input  logic [WORD_SIZE-1:0] fld_imm_i,
   output logic                 mem_we_o,
   output logic [ADDR_SIZE-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0] mem_wdata_o,
   input  logic                 mem_ready_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
   logic [CNT_SIZE-1:0]  acc_q, acc_d;
   logic [CNT_SIZE-1:0]  wr_q, wr_d;
   logic                 stage_valid_q, stage_valid_d;
   logic [WORD_SIZE-1:0] stage_q, stage_d;
   logic                 err_q, err_d;

   logic [WORD_SIZE-1:0] pack_word;
   logic                 pack_err;
   logic                 fld_acc, wr_acc;

   segre_instr_pack #(
      .WORD_SIZE(WORD_SIZE),
      .REG_SIZE (REG_SIZE)
   ) u_pack (
      .fmt_i   (fld_fmt_i),
      .opcode_i(fld_opcode_i),
      .funct3_i(fld_funct3_i),
      .funct7_i(fld_funct7_i),
      .rd_i    (fld_rd_i),
      .rs1_i   (fld_rs1_i),
      .rs2_i   (fld_rs2_i),
      .imm_i   (fld_imm_i),
      .word_o  (pack_word),
      .err_o   (pack_err)
   );

   // A field may enter whenever the stage is empty or draining this same cycle.
   assign wr_acc      = stage_valid_q && mem_ready_i;
   assign fld_ready_o = (state_q == S_RUN) && (acc_q < cnt_q) && (!stage_valid_q || mem_ready_i);
   assign fld_acc     = fld_valid_i && fld_ready_o;

   assign mem_we_o    = stage_valid_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = stage_q;
   assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_o      = (state_q == S_DONE);
   assign err_o       = err_q;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      wr_d          = wr_q;
      stage_valid_d = stage_valid_q;
      stage_d       = stage_q;
      err_d         = err_q;

      if (wr_acc) begin
         wr_d          = wr_q + 1'b1;
         addr_d        = addr_q + ADDR_SIZE'(4);
         stage_valid_d = 1'b0;
      end
      if (fld_acc) begin
         acc_d         = acc_q + 1'b1;
         stage_valid_d = 1'b1;
         stage_d       = pack_word;
         if (pack_err) err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               addr_d  = base_addr_i & ~ADDR_SIZE'(3);
               cnt_d   = count_i;
               acc_d   = '0;
               wr_d    = '0;
               err_d   = 1'b0;
               state_d = (count_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN:   if (fld_acc && (acc_d == cnt_q)) state_d = S_DRAIN;
         S_DRAIN: if (wr_d == cnt_q) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         cnt_q         <= '0;
         acc_q         <= '0;
         wr_q          <= '0;
         stage_valid_q <= 1'b0;
         stage_q       <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         acc_q         <= acc_d;
         wr_q          <= wr_d;
         stage_valid_q <= stage_valid_d;
         stage_q       <= stage_d;
         err_q         <= err_d;
      end
   end

endmodule

// File: doc/segre_instr_encoder.md
Name: segre_instr_encoder

Overview:
- Streaming RV32I instruction assembler, the inverse of the decode stage.
- Takes decoded instruction fields (format, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake and packs each set into a 32-bit instruction word.
- Writes the words to instruction memory at consecutive word addresses.
- Used by boot/self-test infrastructure to load programs into imem without an external loader.

Parameters:
- WORD_SIZE, 32, instruction/data word width
- REG_SIZE, 5, register index width
- ADDR_SIZE, 32, imem byte-address width
- CNT_SIZE, 16, width of the instruction-count register

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  begin a program load; sampled only in IDLE
- base_addr_i  in  ADDR_SIZE  first write address; bits [1:0] ignored and forced to 0
- count_i  in  CNT_SIZE  number of instructions to write
- fld_valid_i  in  1  field set valid
- fld_ready_o  out  1  field set accepted when valid&&ready
- fld_fmt_i  in  3  instr_fmt_e: R/I/S/B/U/J
- fld_opcode_i  in  7  opcode_e
- fld_funct3_i  in  3  funct3
- fld_funct7_i  in  7  funct7 (R only; I-type shifts place it in imm[11:5])
- fld_rd_i, fld_rs1_i, fld_rs2_i  in  REG_SIZE  register indices
- fld_imm_i  in  WORD_SIZE  full unshifted immediate, byte offset for B/J
- mem_we_o  out  1  imem write request
- mem_addr_o  out  ADDR_SIZE  write byte address
- mem_wdata_o  out  WORD_SIZE  encoded instruction
- mem_ready_i  in  1  imem accepts write when we&&ready
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle pulse on completion
- err_o  out  1  sticky field-error flag, cleared on start accept

Behaviour:
- Reset: all outputs 0; state IDLE; stage register invalid; address, counters and err cleared. Reset mid-load drops the pending word and ignores the remaining fields.
- FSM: IDLE -> RUN on start_i. RUN -> DRAIN when accepted-field count reaches count_i. DRAIN -> DONE when written count equals count_i. DONE -> IDLE unconditionally after 1 cycle, with done_o=1 in DONE.
- start_i with count_i=0: IDLE -> DONE directly; done_o pulses one cycle after start; no writes.
- start_i outside IDLE: ignored.
- Encoding:
  - Combinational from the fields, registered into a single stage register.
  - Latency: 1 cycle from field acceptance to mem_we_o.
  - Bit positions follow the RV32I base formats exactly.
  - U: imm[31:12].
  - I: imm[11:0].
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0]}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12]}.
  - Unused fields of a format are ignored.
- fld_ready_o = (state==RUN) && (accepted < count) && (!stage_valid || mem_ready_i). Full-throughput: one word per cycle with mem_ready_i held high.
- mem_we_o = stage_valid. While mem_we_o && !mem_ready_i, mem_addr_o and mem_wdata_o hold stable.
- On each accepted write: mem_addr += 4, wrapping modulo 2^ADDR_SIZE.
- Simultaneous write-accept and field-accept in the same cycle: the stage register reloads with no bubble.
- Undefined fld_fmt_i value: encodes as NOP 0x00000013 and sets err_o.

Optional Feature:
- SEGRE_ENC_RANGE_CHECK_EN defined: immediates are range-checked.
  - I/S: imm must sign-fit 12 bits.
  - B: 13 bits and even.
  - J: 21 bits and even.
  - U: imm[11:0]==0.
  - A violating field set is written as NOP 0x00000013 and sets err_o.
- Undefined: immediates are silently truncated to the format's bits; err_o is set only by an invalid fmt.

Decomposition:
- segre_pkg additions: instr_fmt_e (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J) and the NOP_INSTR constant 32'h0000_0013.
- Existing opcode_e is reused.
- Sub-module segre_instr_pack: purely combinational field-to-word packer with an error output. The top level owns the FSM, counters, stage register and handshake.

Test Plan:
- base=0x100, count=2, no backpressure. Fields ADDI x1,x0,5 then ADD x3,x1,x2 -> writes 0x00500093 @0x100, then 0x002081B3 @0x104, on consecutive cycles; done_o pulses after the second write.
- SW x2,8(x1) -> 0x0020A423. BEQ x0,x0,-4 -> 0xFE000EE3. JAL x1,2048 -> 0x001000EF.
- mem_ready_i held low 3 cycles during a write -> address and data stable; fld_ready_o low while the stage register is full; no word lost or duplicated.
- count_i=0 -> no mem_we_o; done_o exactly one cycle after start; busy_o stays 0.
- With SEGRE_ENC_RANGE_CHECK_EN: ADDI imm=4096 -> writes 0x00000013; err_o=1 and persists until the next start. Without the macro -> writes 0x00000013 (truncated imm=0); err_o=0.
- rst_i asserted mid-load with a stalled word pending -> next cycle all outputs 0 and state IDLE; a fresh start loads correctly from the new base.
